// File: rtl/path_neighbor_gen_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// path_neighbor_gen_if : request / neighbour-beat bundle for path_neighbor_gen
// Rev 1.0
// -----------------------------------------------------------------------------
interface path_neighbor_gen_if #(
  parameter int W = 16
);
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] idx_i;
  logic [W-1:0] x_i;
  logic [W-1:0] y_i;
  logic         nb_valid_o;
  logic         nb_ready_i;
  logic [W-1:0] nb_idx_o;
  logic [2:0]   nb_dir_o;
  logic         nb_last_o;
  logic         done_o;
  logic [3:0]   nb_count_o;
  logic         err_o;

  modport master (
    output in_valid_i, idx_i, x_i, y_i, nb_ready_i,
    input  in_ready_o, nb_valid_o, nb_idx_o, nb_dir_o, nb_last_o,
           done_o, nb_count_o, err_o
  );

  modport slave (
    input  in_valid_i, idx_i, x_i, y_i, nb_ready_i,
    output in_ready_o, nb_valid_o, nb_idx_o, nb_dir_o, nb_last_o,
           done_o, nb_count_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/path_neighbor_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// path_neighbor_gen : iterative-divide grid neighbour streamer (4/8-connected)
// Rev 1.0
// -----------------------------------------------------------------------------
module path_neighbor_gen #(
  parameter int W       = 16,
  parameter int DIAG_EN = 0
) (
  input  wire logic          system1000,
  input  wire logic          system1000_rst,
  path_neighbor_gen_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  localparam int                  c_step_w    = (W > 1) ? $clog2(W) : 1;
  localparam logic [c_step_w-1:0] c_last_step = c_step_w'(W - 1);
  localparam logic [c_step_w-1:0] c_step_one  = c_step_w'(1);
  localparam logic [W-1:0]        c_one_w     = W'(1);
  localparam logic [W:0]          c_one_x     = (W + 1)'(1);

  state_t              state_q, state_d;
  logic [W-1:0]        idx_q, idx_d, x_q, x_d, y_q, y_d;
  logic [W-1:0]        rem_q, rem_d, quo_q, quo_d;
  logic [c_step_w-1:0] step_q, step_d;
  logic [7:0]          mask_q, mask_d;
  logic [3:0]          count_q, count_d, nb_count_q, nb_count_d;
  logic                in_ready_q, in_ready_d, nb_valid_q, nb_valid_d;
  logic                nb_last_q, nb_last_d, done_q, done_d, err_q, err_d;
  logic [W-1:0]        nb_idx_q, nb_idx_d;
  logic [2:0]          nb_dir_q, nb_dir_d;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  logic [W:0]   w_shift;
  logic         w_ge;
  logic [W-1:0] w_rem_nxt, w_quo_nxt;
  assign w_shift   = {rem_q, quo_q[W-1]};
  assign w_ge      = w_shift >= {1'b0, x_q};
  assign w_rem_nxt = w_ge ? (w_shift[W-1:0] - x_q) : w_shift[W-1:0];
  assign w_quo_nxt = {quo_q[W-2:0], w_ge};

  logic       w_row_ok, w_dn, w_rt, w_up, w_lt;
  logic [3:0] w_diag;
  logic [7:0] w_mask;
  assign w_row_ok = w_quo_nxt < y_q;
  assign w_dn     = ({1'b0, w_quo_nxt} + c_one_x) < {1'b0, y_q};
  assign w_rt     = ({1'b0, w_rem_nxt} + c_one_x) < {1'b0, x_q};
  assign w_up     = w_quo_nxt != '0;
  assign w_lt     = w_rem_nxt != '0;

  generate
    if (DIAG_EN != 0) begin : g_diag
      assign w_diag = {w_dn & w_lt, w_up & w_lt, w_up & w_rt, w_dn & w_rt};
    end else begin : g_no_diag
      assign w_diag = 4'b0000;
    end
  endgenerate

  assign w_mask = w_row_ok ? {w_diag, w_lt, w_up, w_rt, w_dn} : 8'h00;

  function automatic logic [2:0] low_dir(input logic [7:0] m);
    logic [2:0] d;
    d = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) d = 3'(i);
    end
    return d;
  endfunction

  function automatic logic [W-1:0] step_idx(input logic [2:0] d, input logic [W-1:0] idx,
                                            input logic [W-1:0] x);
    logic [W-1:0] r;
    case (d)
      3'd0:    r = idx + x;
      3'd1:    r = idx + c_one_w;
      3'd2:    r = idx - x;
      3'd3:    r = idx - c_one_w;
      3'd4:    r = idx + x + c_one_w;
      3'd5:    r = idx - x + c_one_w;
      3'd6:    r = idx - x - c_one_w;
      default: r = idx + x - c_one_w;
    endcase
    return r;
  endfunction

  // Next beat comes from the fresh mask at the end of DIV, else from what remains
  logic [7:0] w_rest, w_load, w_load_rest;
  logic [2:0] w_load_dir;
  assign w_rest      = mask_q & ~(8'h01 << nb_dir_q);
  assign w_load      = (state_q == S_DIV) ? w_mask : w_rest;
  assign w_load_dir  = low_dir(w_load);
  assign w_load_rest = w_load & ~(8'h01 << w_load_dir);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    x_d        = x_q;
    y_d        = y_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    step_d     = step_q;
    mask_d     = mask_q;
    count_d    = count_q;
    nb_valid_d = nb_valid_q;
    nb_idx_d   = nb_idx_q;
    nb_dir_d   = nb_dir_q;
    nb_last_d  = nb_last_q;
    nb_count_d = nb_count_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid_i && in_ready_q) begin
          idx_d = bus.idx_i;
          x_d   = bus.x_i;
          y_d   = bus.y_i;
          if (bus.x_i == '0) begin
            done_d     = 1'b1;
            err_d      = 1'b1;
            nb_count_d = 4'd0;
          end else begin
            state_d = S_DIV;
            rem_d   = '0;
            quo_d   = bus.idx_i;
            step_d  = '0;
          end
        end
      end
      S_DIV: begin
        rem_d  = w_rem_nxt;
        quo_d  = w_quo_nxt;
        step_d = step_q + c_step_one;
        if (step_q == c_last_step) begin
          mask_d  = w_mask;
          count_d = 4'd0;
          if (w_mask == 8'h00) begin
            state_d    = S_IDLE;
            done_d     = 1'b1;
            err_d      = ~w_row_ok;
            nb_count_d = 4'd0;
          end else begin
            state_d    = S_EMIT;
            nb_valid_d = 1'b1;
            nb_dir_d   = w_load_dir;
            nb_idx_d   = step_idx(w_load_dir, idx_q, x_q);
            nb_last_d  = (w_load_rest == 8'h00);
          end
        end
      end
      S_EMIT: begin
        if (nb_valid_q && bus.nb_ready_i) begin
          mask_d  = w_rest;
          count_d = count_q + 4'd1;
          if (w_rest == 8'h00) begin
            state_d    = S_IDLE;
            nb_valid_d = 1'b0;
            nb_idx_d   = '0;
            nb_dir_d   = 3'd0;
            nb_last_d  = 1'b0;
            done_d     = 1'b1;
            nb_count_d = count_q + 4'd1;
          end else begin
            nb_dir_d  = w_load_dir;
            nb_idx_d  = step_idx(w_load_dir, idx_q, x_q);
            nb_last_d = (w_load_rest == 8'h00);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      step_q     <= '0;
      mask_q     <= 8'h00;
      count_q    <= 4'd0;
      in_ready_q <= 1'b0;
      nb_valid_q <= 1'b0;
      nb_idx_q   <= '0;
      nb_dir_q   <= 3'd0;
      nb_last_q  <= 1'b0;
      nb_count_q <= 4'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      step_q     <= step_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      nb_valid_q <= nb_valid_d;
      nb_idx_q   <= nb_idx_d;
      nb_dir_q   <= nb_dir_d;
      nb_last_q  <= nb_last_d;
      nb_count_q <= nb_count_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready_o = in_ready_q;
  assign bus.nb_valid_o = nb_valid_q;
  assign bus.nb_idx_o   = nb_idx_q;
  assign bus.nb_dir_o   = nb_dir_q;
  assign bus.nb_last_o  = nb_last_q;
  assign bus.done_o     = done_q;
  assign bus.nb_count_o = nb_count_q;
  assign bus.err_o      = err_q;
endmodule
`default_nettype wire

// File: tb/tb_path_neighbor_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_path_neighbor_gen : directed + random requests against a grid-geometry model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_path_neighbor_gen;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  path_neighbor_gen_if #(.W(W)) if0 ();
  path_neighbor_gen_if #(.W(W)) if1 ();

  path_neighbor_gen #(.W(W), .DIAG_EN(0)) dut0 (
    .system1000(clk), .system1000_rst(rst), .bus(if0.slave)
  );
  path_neighbor_gen #(.W(W), .DIAG_EN(1)) dut1 (
    .system1000(clk), .system1000_rst(rst), .bus(if1.slave)
  );

  typedef struct packed {
    logic        in_ready;
    logic        nb_valid;
    logic [15:0] nb_idx;
    logic [2:0]  nb_dir;
    logic        nb_last;
    logic        done;
    logic [3:0]  cnt;
    logic        err;
  } obs_t;

  typedef struct {
    int dir;
    int idx;
  } beat_t;

  // Row/column offsets of each direction code
  int dr[8] = '{1, 0, -1, 0, 1, -1, -1, 1};
  int dc[8] = '{0, 1, 0, -1, 1, 1, -1, -1};

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) o = '{if1.in_ready_o, if1.nb_valid_o, if1.nb_idx_o, if1.nb_dir_o, if1.nb_last_o,
                   if1.done_o, if1.nb_count_o, if1.err_o};
    else     o = '{if0.in_ready_o, if0.nb_valid_o, if0.nb_idx_o, if0.nb_dir_o, if0.nb_last_o,
                   if0.done_o, if0.nb_count_o, if0.err_o};
    return o;
  endfunction

  task automatic drive(input bit sel, input bit v, input int idx, input int x, input int y,
                       input bit rdy);
    if (sel) begin
      if1.in_valid_i = v; if1.idx_i = 16'(idx); if1.x_i = 16'(x); if1.y_i = 16'(y);
      if1.nb_ready_i = rdy;
    end else begin
      if0.in_valid_i = v; if0.idx_i = 16'(idx); if0.x_i = 16'(x); if0.y_i = 16'(y);
      if0.nb_ready_i = rdy;
    end
  endtask

  task automatic run_req(input bit sel, input int idx, input int x, input int y,
                         input bit bp, input bit poke, input string tag);
    beat_t q[$];
    bit    exp_err, got_done, seen_v, stalled, rdy;
    int    row, col, r, c, nexp, cyc, beats;
    obs_t  o, prev;
    exp_err = 1'b0;
    if (x == 0) exp_err = 1'b1;
    else begin
      row = idx / x;
      col = idx % x;
      if (row >= y) exp_err = 1'b1;
      else begin
        for (int d = 0; d < (sel ? 8 : 4); d++) begin
          r = row + dr[d];
          c = col + dc[d];
          if (r >= 0 && r < y && c >= 0 && c < x) q.push_back('{d, r * x + c});
        end
      end
    end
    nexp = q.size();

    cyc = 0;
    o = sample(sel);
    while (!o.in_ready && cyc < 50) begin
      @(negedge clk);
      o = sample(sel);
      cyc++;
    end
    check({tag, ":in_ready"}, 32'(o.in_ready), 32'd1);
    drive(sel, 1'b1, idx, x, y, 1'b0);
    @(negedge clk);
    drive(sel, 1'b0, 0, 0, 0, 1'b0);

    cyc = 1; got_done = 0; seen_v = 0; stalled = 0; beats = 0; prev = '0;
    while (cyc < 200) begin
      o = sample(sel);
      if (o.done) begin
        got_done = 1;
        break;
      end
      rdy = bp ? (cyc % 2 == 1) : 1'b1;
      if (stalled)
        check({tag, ":hold"}, {o.nb_valid, o.nb_idx, o.nb_dir, o.nb_last},
              {1'b1, prev.nb_idx, prev.nb_dir, prev.nb_last});
      if (o.nb_valid) begin
        if (!seen_v) begin
          seen_v = 1;
          check({tag, ":latency"}, 32'(cyc), 32'(W + 1));
        end
        if (q.size() > 0) begin
          if (!stalled) begin
            check({tag, ":idx"},  32'(o.nb_idx),  32'(q[0].idx));
            check({tag, ":dir"},  32'(o.nb_dir),  32'(q[0].dir));
            check({tag, ":last"}, 32'(o.nb_last), 32'(q.size() == 1));
          end
          if (rdy) begin
            void'(q.pop_front());
            beats++;
          end
        end else begin
          check({tag, ":extra_beat"}, 32'(o.nb_valid), 32'd0);
        end
      end
      stalled = o.nb_valid && !rdy;
      prev = o;
      drive(sel, poke ? 1'($urandom_range(0, 1)) : 1'b0, int'($urandom_range(0, 40)), 4, 3, rdy);
      @(negedge clk);
      cyc++;
    end
    drive(sel, 1'b0, 0, 0, 0, 1'b0);
    check({tag, ":done_seen"}, 32'(got_done), 32'd1);
    check({tag, ":count"},     32'(o.cnt),    32'(nexp));
    check({tag, ":err"},       32'(o.err),    32'(exp_err));
    check({tag, ":beats"},     32'(beats),    32'(nexp));
    if (nexp > 0) check({tag, ":ready_at_done"}, 32'(o.in_ready), 32'd1);
    @(negedge clk);
    o = sample(sel);
    check({tag, ":done_pulse"}, 32'(o.done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   hs, cyc, rx, ry, ridx;
    bit   rsel, rbp;
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state_d0", 32'(sample(1'b0)), 32'd0);
    check("reset_state_d1", 32'(sample(1'b1)), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    o = sample(1'b0);
    check("ready_after_reset", 32'(o.in_ready), 32'd1);

    run_req(1'b0, 5,  4, 3, 1'b0, 1'b0, "d4_idx5");
    run_req(1'b0, 0,  4, 3, 1'b0, 1'b0, "d4_idx0");
    run_req(1'b0, 11, 4, 3, 1'b0, 1'b0, "d4_idx11");
    run_req(1'b1, 5,  4, 3, 1'b0, 1'b0, "d8_idx5");
    run_req(1'b1, 0,  4, 3, 1'b0, 1'b0, "d8_idx0");
    run_req(1'b0, 5,  4, 3, 1'b1, 1'b1, "d4_backpressure");
    run_req(1'b1, 5,  4, 3, 1'b1, 1'b1, "d8_backpressure");
    run_req(1'b0, 3,  0, 3, 1'b0, 1'b0, "x_zero");
    run_req(1'b0, 12, 4, 3, 1'b0, 1'b0, "row_range");
    run_req(1'b1, 12, 4, 3, 1'b0, 1'b0, "row_range_d8");
    run_req(1'b0, 0,  1, 1, 1'b0, 1'b0, "grid_1x1");
    run_req(1'b1, 0,  1, 1, 1'b0, 1'b0, "grid_1x1_d8");

    // Reset while beats are still pending
    drive(1'b0, 1'b1, 5, 4, 3, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
    hs = 0; cyc = 0;
    while (hs < 2 && cyc < 100) begin
      o = sample(1'b0);
      if (o.nb_valid) hs++;
      @(negedge clk);
      cyc++;
    end
    check("mid_emit_beats", 32'(hs), 32'd2);
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
    @(negedge clk);
    check("mid_emit_reset_outputs", 32'(sample(1'b0)), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    o = sample(1'b0);
    check("mid_emit_ready_after", 32'(o.in_ready), 32'd1);
    run_req(1'b0, 0, 4, 3, 1'b0, 1'b0, "post_reset_idx0");

    for (int k = 0; k < 24; k++) begin
      rsel = 1'($urandom_range(0, 1));
      rbp  = 1'($urandom_range(0, 1));
      rx   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      ry   = int'($urandom_range(1, 8));
      ridx = (rx == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, rx * ry + 3));
      run_req(rsel, ridx, rx, ry, rbp, rbp, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/path_neighbor_gen.md
Name: path_neighbor_gen

Overview:
Sequential, parametrised neighbour generator for the grid path-search datapath; successor to the single-direction combinational neighbour lookup.
- Accepts one cell index plus grid dimensions per request.
- Derives row/column with an iterative divider, so there is no combinational `/` or `%`.
- Streams every in-bounds neighbour (4- or 8-connected) over a valid/ready port to the priority-queue feeder.
- Out-of-bounds directions are skipped, never echoed back as the input index.

Parameters:
- W, 16, index/dimension width in bits.
- DIAG_EN, 0, 0 = 4-connected (dirs 0..3); 1 = 8-connected (dirs 0..7).

Ports:
- system1000, input, 1, clock.
- system1000_rst, input, 1, synchronous active-high reset.
- in_valid_i, input, 1, request valid.
- in_ready_o, output, 1, block idle and able to accept.
- idx_i, input, W, cell index (row*x + col).
- x_i, input, W, grid columns.
- y_i, input, W, grid rows.
- nb_valid_o, output, 1, neighbour beat valid.
- nb_ready_i, input, 1, consumer accepts beat.
- nb_idx_o, output, W, neighbour index.
- nb_dir_o, output, 3, direction code of the beat.
- nb_last_o, output, 1, final beat of this request.
- done_o, output, 1, one-cycle pulse when a request completes (normal, empty or error).
- nb_count_o, output, 4, neighbours emitted; valid with done_o.
- err_o, output, 1, one-cycle pulse with done_o on a bad request.

Behaviour:
- Reset and synchronous clear: one clock, synchronous active-high reset.
  - In any state, system1000_rst forces IDLE and drops the request in flight.
  - Every output resets to 0 (in_ready_o included).
  - in_ready_o rises in the first cycle after reset deasserts.
- States are IDLE, DIV, EMIT.
- IDLE:
  - in_ready_o = 1.
  - Accept on in_valid_i && in_ready_o; idx_i, x_i and y_i are captured.
  - If x_i == 0: the next cycle pulses done_o = err_o = 1 with nb_count_o = 0, then stays IDLE.
  - Otherwise go to DIV.
- DIV:
  - in_ready_o = 0.
  - Restoring unsigned divide idx/x, one quotient bit per cycle, exactly W cycles.
  - Result: row = quotient, col = remainder.
  - On the last DIV cycle, compute direction mask m[7:0] and go to EMIT.
- Direction mask (bit set = neighbour exists):
  - 0 down, idx+x, row+1<y.
  - 1 right, idx+1, col+1<x.
  - 2 up, idx-x, row>=1.
  - 3 left, idx-1, col>=1.
  - Only when DIAG_EN=1 (bits 4..7 forced 0 when DIAG_EN=0):
    - 4 down-right, idx+x+1, needs both (0) and (1).
    - 5 up-right, idx-x+1, needs (2) and (1).
    - 6 up-left, idx-x-1, needs (2) and (3).
    - 7 down-left, idx+x-1, needs (0) and (3).
- Range error: if row >= y, treat the request as out of range.
  - The mask is cleared.
  - done_o = err_o = 1 in the first EMIT cycle, then IDLE.
- EMIT:
  - Present the lowest set mask bit.
  - nb_valid_o = 1 with nb_idx_o, nb_dir_o, and nb_last_o = 1 if no higher bit is set.
  - Outputs are held stable while nb_valid_o && !nb_ready_i.
  - On handshake: clear that bit and increment the count.
  - The next set bit appears in the following cycle (one beat per cycle at full throughput).
  - The cycle after the last handshake: done_o = 1, nb_count_o = count, state returns to IDLE, and in_ready_o = 1 in that same cycle.
- Empty mask (e.g. 1x1 grid): no beats, nb_valid_o never rises; done_o with nb_count_o = 0 and err_o = 0 in the first EMIT cycle.
- Latency: with no backpressure, the first nb_valid_o is high W+1 cycles after the accept cycle.
- Arithmetic:
  - All math is unsigned W-bit.
  - The caller guarantees x*y <= 2^W; this is not checked.
  - Emitted indices never wrap because of the mask checks.
- Concurrency: in_valid_i is ignored outside IDLE. nb_ready_i is ignored when nb_valid_o = 0.

Test Plan:
- DIAG_EN=0, x=4, y=3, idx=5, nb_ready_i=1:
  - Beats (9,d0), (6,d1), (1,d2), (4,d3); last only on 4.
  - done_o with count 4; first valid 17 cycles after accept.
- DIAG_EN=0, corners of the same grid:
  - idx=0 -> (4,d0), (1,d1), count 2.
  - idx=11 -> (7,d2), (10,d3), count 2.
- DIAG_EN=1, x=4, y=3, idx=5:
  - Beats 9, 6, 1, 4, 10, 2, 0, 8 with dirs 0..7; count 8.
  - Then idx=0 -> 4, 1, 5 (d0, d1, d4).
- Backpressure: idx=5 with nb_ready_i toggling 0/1 each cycle:
  - Each beat is held unchanged while ready = 0.
  - Order and count are identical to the first scenario.
  - in_valid_i pulses during EMIT are ignored.
- Errors and empty requests:
  - x=0 -> done_o + err_o, count 0, no beats.
  - x=4, y=3, idx=12 -> err_o, no beats.
  - x=1, y=1, idx=0 -> done_o, err_o=0, count 0.
- Reset mid-EMIT (after 2 beats of idx=5):
  - All outputs 0 in the cycle after reset.
  - in_ready_o = 1 after release.
  - A new request idx=0 produces a clean 2-beat response.
